// File: rtl/fa_2bit.sv
// Ripple-carry full adder built from a chain of one-bit cells; combinational sum/carry plus a registered copy.
// Optional signed-overflow outputs (ovf, ovf_r) are enabled by defining FA_2BIT_OVF_EN.
module fa_2bit #(
    parameter int unsigned WIDTH = 2
) (
    output logic             ripout,
    output logic [WIDTH-1:0] somma,
    input  logic             ripin,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] somma_r,
    output logic             ripout_r
`ifdef FA_2BIT_OVF_EN
    ,
    output logic             ovf,
    output logic             ovf_r
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] c;

    always_comb begin
        c     = '0;
        somma = '0;
        c[0]  = ripin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            somma[i] = x1[i] ^ x2[i] ^ c[i];
            c[i+1]   = (x1[i] & x2[i]) | (c[i] & (x1[i] ^ x2[i]));
        end
    end

    assign ripout = c[WIDTH];

`ifdef FA_2BIT_OVF_EN
    assign ovf = c[WIDTH-1] ^ c[WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            somma_r  <= '0;
            ripout_r <= 1'b0;
`ifdef FA_2BIT_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            somma_r  <= somma;
            ripout_r <= ripout;
`ifdef FA_2BIT_OVF_EN
            ovf_r    <= ovf;
`endif
        end
    end

endmodule

// File: tb/tb_fa_2bit.sv
// Self-checking bench for fa_2bit: directed and randomized steps against an integer-arithmetic reference model.
module tb_fa_2bit;

    localparam int unsigned WIDTH = 2;
    localparam int MOD = 1 << WIDTH;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             ripin;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic             ripout;
    logic [WIDTH-1:0] somma;
    logic [WIDTH-1:0] somma_r;
    logic             ripout_r;
`ifdef FA_2BIT_OVF_EN
    logic             ovf;
    logic             ovf_r;
`endif

    int tests;
    int fails;

    fa_2bit #(.WIDTH(WIDTH)) dut (
        .ripout   (ripout),
        .somma    (somma),
        .ripin    (ripin),
        .x1       (x1),
        .x2       (x2),
        .clk      (clk),
        .rst_n    (rst_n),
        .somma_r  (somma_r),
        .ripout_r (ripout_r)
`ifdef FA_2BIT_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_r    (ovf_r)
`endif
    );

    // Clock stays low until the bench enables it.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer sum, split into low WIDTH bits and carry.
    function automatic int model_sum(input int a, input int b, input int ci);
        return (a + b + ci) % MOD;
    endfunction

    function automatic int model_carry(input int a, input int b, input int ci);
        return (a + b + ci) / MOD;
    endfunction

    // Signed overflow: the signed result falls outside the WIDTH-bit two's-complement range.
    function automatic int model_ovf(input int a, input int b, input int ci);
        int sa, sb, s;
        sa = (a >= MOD / 2) ? a - MOD : a;
        sb = (b >= MOD / 2) ? b - MOD : b;
        s  = sa + sb + ci;
        return (s > MOD / 2 - 1 || s < -(MOD / 2)) ? 1 : 0;
    endfunction

    task automatic apply(input int a, input int b, input int ci);
        x1    = WIDTH'(a);
        x2    = WIDTH'(b);
        ripin = 1'(ci);
    endtask

    int pa, pb, pc;
    int na, nb, nc;

    initial begin
        tests  = 0;
        fails  = 0;
        clk_en = 1'b0;
        rst_n  = 1'b1;
        apply(0, 0, 0);
        #1 rst_n = 1'b0;

        // No clock, reset held low
        apply(1, 2, 0);
        #1;
        check("nclk_somma", 32'(somma), 32'd3);
        check("nclk_ripout", 32'(ripout), 32'd0);
        check("rst_somma_r", 32'(somma_r), 32'd0);
        check("rst_ripout_r", 32'(ripout_r), 32'd0);

        apply(1, 3, 1);
        #1;
        check("nclk2_somma", 32'(somma), 32'd1);
        check("nclk2_ripout", 32'(ripout), 32'd1);

        for (int a = 0; a < MOD; a++)
            for (int b = 0; b < MOD; b++)
                for (int ci = 0; ci < 2; ci++) begin
                    apply(a, b, ci);
                    #1;
                    check("sweep_sum", {30'd0, ripout, somma}, 32'(a + b + ci));
                end
        check("sweep_hold_somma_r", 32'(somma_r), 32'd0);

        apply(0, 0, 0);
        #1;
        check("zero_somma", 32'(somma), 32'd0);
        check("zero_ripout", 32'(ripout), 32'd0);

        // Start clock, release reset between edges
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        apply(3, 3, 1);
        #1;
        check("pre_edge_somma_r", 32'(somma_r), 32'd0);
        check("ones_somma", 32'(somma), 32'd3);
        check("ones_ripout", 32'(ripout), 32'd1);
        @(posedge clk);
        #1;
        check("lat1_somma_r", 32'(somma_r), 32'd3);
        check("lat1_ripout_r", 32'(ripout_r), 32'd1);

        // Randomized: registered outputs lag combinational by one edge
        pa = 3; pb = 3; pc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            na = int'($urandom_range(MOD - 1, 0));
            nb = int'($urandom_range(MOD - 1, 0));
            nc = int'($urandom_range(1, 0));
            apply(na, nb, nc);
            #1;
            check("rnd_somma", 32'(somma), 32'(model_sum(na, nb, nc)));
            check("rnd_ripout", 32'(ripout), 32'(model_carry(na, nb, nc)));
            check("rnd_hold_somma_r", 32'(somma_r), 32'(model_sum(pa, pb, pc)));
`ifdef FA_2BIT_OVF_EN
            check("rnd_ovf", 32'(ovf), 32'(model_ovf(na, nb, nc)));
`endif
            @(posedge clk);
            #1;
            check("rnd_somma_r", 32'(somma_r), 32'(model_sum(na, nb, nc)));
            check("rnd_ripout_r", 32'(ripout_r), 32'(model_carry(na, nb, nc)));
`ifdef FA_2BIT_OVF_EN
            check("rnd_ovf_r", 32'(ovf_r), 32'(model_ovf(na, nb, nc)));
`endif
            pa = na; pb = nb; pc = nc;
        end

        // Asynchronous reset mid-cycle while registered outputs are nonzero
        @(negedge clk);
        apply(3, 3, 1);
        @(posedge clk);
        #1;
        check("pre_rst_somma_r", 32'(somma_r), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_somma_r", 32'(somma_r), 32'd0);
        check("async_ripout_r", 32'(ripout_r), 32'd0);
        check("async_somma", 32'(somma), 32'd3);
        check("async_ripout", 32'(ripout), 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold_somma_r", 32'(somma_r), 32'd0);
        check("rst_hold_ripout_r", 32'(ripout_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FA_2BIT_OVF_EN
        apply(1, 1, 0);
        #1;
        check("ovf_1p1", 32'(ovf), 32'(model_ovf(1, 1, 0)));
        check("ovf_1p1_const", 32'(ovf), 32'd1);
        @(posedge clk);
        #1;
        check("ovf_r_1p1", 32'(ovf_r), 32'd1);
        @(negedge clk);
        apply(3, 3, 0);
        #1;
        check("ovf_3p3", 32'(ovf), 32'd0);
        check("ovf_r_hold", 32'(ovf_r), 32'd1);
        @(posedge clk);
        #1;
        check("ovf_r_3p3", 32'(ovf_r), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fa_2bit.md
Name: fa_2bit

Overview:
- Two-bit ripple-carry full adder: WIDTH-bit operands x1 and x2 plus carry-in ripin produce sum somma and carry-out ripout.
- Primary outputs are purely combinational, so the block can sit unclocked in any datapath.
- A registered copy of the result is also provided for pipelined consumers, with one clock and an asynchronous active-low reset.
- Leaf arithmetic cell used by wider adders and ALU slices.

Parameters:
- WIDTH, 2, operand and sum width in bits. Only 2 is required for this block; the RTL must stay correct for any WIDTH >= 1.

Ports:
- clk, input, 1, clock; rising edge updates the registered outputs only.
- rst_n, input, 1, reset; asynchronous, active-low (decided).
- ripout, output, 1, combinational carry-out.
- somma, output, WIDTH, combinational sum.
- ripin, input, 1, carry-in.
- x1, input, WIDTH, operand A, unsigned.
- x2, input, WIDTH, operand B, unsigned.
- somma_r, output, WIDTH, registered sum.
- ripout_r, output, 1, registered carry-out.

Positional order of the first five ports is fixed for existing instantiations: ripout, somma, ripin, x1, x2. clk, rst_n and the registered outputs are connected by name.

Behaviour:
- Arithmetic: {ripout, somma} = x1 + x2 + ripin, computed at WIDTH+1 bits with no truncation before the carry is taken.
- Structure: built as a chain of WIDTH one-bit full-adder cells.
  - Bit i: s = a ^ b ^ c; cout = (a & b) | (c & (a ^ b)).
  - Bit 0 carry-in = ripin; ripout = carry-out of bit WIDTH-1.
- Combinational outputs:
  - Zero clock latency; they follow the inputs whenever the inputs change.
  - Independent of clk and rst_n, and valid even while rst_n is low.
- Registered outputs:
  - On each rising clk edge with rst_n high: somma_r <= somma, ripout_r <= ripout. Latency is 1 cycle.
  - rst_n low: somma_r = 0 and ripout_r = 0 immediately, with no clock required. They are held at 0 while rst_n is low.
  - First capture happens on the first rising edge after rst_n deasserts.
- X/Z on any input propagates to the outputs; no sanitising.
- Boundary cases:
  - All-ones inputs (x1=3, x2=3, ripin=1): somma=3, ripout=1.
  - All zeros: somma=0, ripout=0.
- No handshake and no state machine.

Optional Feature:
- Macro: FA_2BIT_OVF_EN.
- When defined:
  - Adds output ovf (1 bit, combinational) = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - Adds output ovf_r (1 bit): registered like ripout_r, reset to 0.
- When undefined:
  - Neither port exists and no related logic is generated.
  - All other behaviour is identical.

Test Plan:
- No clock running, rst_n=0, x1=1, x2=2, ripin=0 -> somma=3, ripout=0 within delta time; somma_r=0, ripout_r=0.
- Then x1=1, x2=3, ripin=1 -> somma=1, ripout=1.
- Exhaustive sweep of x1, x2 in 0..3 and ripin in 0..1 (32 cases) -> {ripout, somma} equals the integer sum.
- Release rst_n, clock running, apply x1=3, x2=3, ripin=1 -> somma_r=3, ripout_r=1 exactly one rising edge later.
- Assert rst_n low between clock edges while somma_r is nonzero -> somma_r and ripout_r go to 0 immediately; combinational outputs unchanged.
- With FA_2BIT_OVF_EN defined:
  - x1=1, x2=1, ripin=0 -> ovf=1.
  - x1=3, x2=3, ripin=0 -> ovf=0.
  - ovf_r follows ovf one cycle later.
